score_sched: RTL and testbench

Scheduler that sits between the game logic and the score datapath (BCD score accumulator plus serial 7-segment shifter). It queues line-clear events, converts each into a point count, and applies it to a 3-digit BCD score one unit per clock. After each update, or after a clear, it starts exactly one display refresh through a start/busy handshake with the shifter. It also arbitrates score clears against pending adds.

---
 rtl/score_sched_if.sv | 24 ++
 rtl/score_sched.sv | 183 ++++++++++++++++++
 tb/tb_score_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_sched_if.sv
// Handshake bundle between the game logic / display shifter and score_sched.
// The master drives events and the shifter busy line; the slave is the scheduler.
interface score_sched_if;
  logic        hit;
  logic [1:0]  lineCount;
  logic        clear;
  logic        disp_busy;
  logic        disp_start;
  logic [11:0] score;
  logic        busy;
  logic [2:0]  pending;
  logic        dropped;
  logic        sat;

  modport master (
    output hit, lineCount, clear, disp_busy,
    input  disp_start, score, busy, pending, dropped, sat
  );

  modport slave (
    input  hit, lineCount, clear, disp_busy,
    output disp_start, score, busy, pending, dropped, sat
  );
endinterface

// File: rtl/score_sched.sv
// Queues line-clear events, adds their points to a saturating 3-digit BCD score one
// unit per clock, and issues exactly one display refresh per update or clear.
module score_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] SAT_VALUE  = 12'h999
) (
  input  logic         clk,
  input  logic         rst,
  score_sched_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, ADD, REQ, START, WAIT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_wdata_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clr_pend_q, clr_pend_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             wait_first_q, wait_first_d;
  logic [11:0]      score_q, score_d;
  logic             sat_q, sat_d;
  logic             dropped_q, dropped_d;
  logic             disp_start_q, disp_start_d;
  logic             busy_q, busy_d;

  logic             fifo_full, fifo_empty, push, pop, service_clr;
  logic [12:0]      inc;

  function automatic logic [3:0] points_of(input logic [1:0] lc);
    case (lc)
      2'd0:    return 4'd1;
      2'd1:    return 4'd3;
      2'd2:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  // Ripple +1 through the three digits; any digit at 9 (or corrupt above it) wraps to 0.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (carry) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Returns {blocked, next score}; packed BCD orders the same as binary.
  function automatic logic [12:0] bcd_inc_sat(input logic [11:0] v);
    if (v >= SAT_VALUE) return {1'b1, v};
    return {1'b0, bcd_inc(v)};
  endfunction

  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign service_clr = (state_q == IDLE) && clr_pend_q;
  assign pop         = (state_q == IDLE) && !clr_pend_q && !fifo_empty && !bus.clear;
  assign push        = bus.hit && !bus.clear && (!fifo_full || pop);
  assign mem_wdata_d = points_of(bus.lineCount);
  assign inc         = bcd_inc_sat(score_q);

  // ---- event queue ----
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = bus.hit && !bus.clear && fifo_full && !pop;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mem_wdata_d;
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (clr_pend_q) state_d = REQ;
             else if (pop)   state_d = ADD;
      ADD:   if (bus.clear)               state_d = IDLE;
             else if (remaining_q <= 4'd1) state_d = REQ;
      REQ:   if (!bus.disp_busy) state_d = START;
      START: state_d = WAIT;
      WAIT:  if (!wait_first_q && !bus.disp_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs (registered from the next state) ----
  always_comb begin
    disp_start_d = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  // ---- score datapath and bookkeeping ----
  always_comb begin
    score_d      = score_q;
    sat_d        = sat_q;
    remaining_d  = remaining_q;
    wait_first_d = (state_q == START);
    clr_pend_d   = clr_pend_q;
    if (service_clr) begin
      score_d = '0;
      sat_d   = 1'b0;
    end
    if (pop) remaining_d = mem_q[rd_ptr_q];
    // A clear arriving mid-add abandons the remaining increments.
    if ((state_q == ADD) && !bus.clear) begin
      score_d     = inc[11:0];
      remaining_d = remaining_q - 4'd1;
      if (inc[12]) sat_d = 1'b1;
    end
    if (bus.clear)        clr_pend_d = 1'b1;
    else if (service_clr) clr_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      clr_pend_q   <= 1'b0;
      remaining_q  <= '0;
      wait_first_q <= 1'b0;
      score_q      <= '0;
      sat_q        <= 1'b0;
      dropped_q    <= 1'b0;
      disp_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      clr_pend_q   <= clr_pend_d;
      remaining_q  <= remaining_d;
      wait_first_q <= wait_first_d;
      score_q      <= score_d;
      sat_q        <= sat_d;
      dropped_q    <= dropped_d;
      disp_start_q <= disp_start_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.disp_start = disp_start_q;
  assign bus.score      = score_q;
  assign bus.busy       = busy_q;
  assign bus.pending    = 3'(count_q);
  assign bus.dropped    = dropped_q;
  assign bus.sat        = sat_q;
endmodule

// File: tb/tb_score_sched.sv
// Bench for score_sched: directed table, multi-cycle corner sequences, and a
// randomized phase scored against a decimal points/refresh model.
module tb_score_sched;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_sched_if bus();

  score_sched #(.FIFO_DEPTH(DEPTH), .SAT_VALUE(12'h999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks    = 0;
  int   n_errors    = 0;
  logic force_busy  = 1'b0;
  int   shifter_len = 0;
  int   sh_cnt      = 0;
  int   ds_count    = 0;
  int   digit_bad   = 0;

  // Shifter stand-in: goes busy the cycle after disp_start for shifter_len cycles.
  assign bus.disp_busy = force_busy || (sh_cnt != 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_cnt <= 0;
    end else if (bus.disp_start) begin
      sh_cnt   <= shifter_len;
      ds_count <= ds_count + 1;
    end else if (sh_cnt > 0) begin
      sh_cnt <= sh_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        if (bus.score[4*i +: 4] > 4'd9) digit_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  lc;
    logic [11:0] exp_score;
  } vec_t;

  vec_t vecs[8];
  int   pts_tab[4] = '{1, 3, 5, 8};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.hit = 1'b0; bus.lineCount = 2'd0; bus.clear = 1'b0;
    force_busy = 1'b0; shifter_len = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_hit(input logic [1:0] lc);
    bus.hit = 1'b1; bus.lineCount = lc;
    @(negedge clk);
    bus.hit = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy && bus.pending == 3'd0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b pending=%0d", name, bus.busy, bus.pending);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    int         ds0, n, k, pts, exp_score, exp_ds;
    logic       exp_sat;
    logic [1:0] lc;

    vecs[0] = '{2'd0, 12'h001};
    vecs[1] = '{2'd1, 12'h004};
    vecs[2] = '{2'd2, 12'h009};
    vecs[3] = '{2'd3, 12'h017};
    vecs[4] = '{2'd3, 12'h025};
    vecs[5] = '{2'd2, 12'h030};
    vecs[6] = '{2'd0, 12'h031};
    vecs[7] = '{2'd1, 12'h034};

    // Reset values while rst is held low
    bus.hit = 1'b0; bus.lineCount = 2'd0; bus.clear = 1'b0;
    @(negedge clk);
    check("rst_score", bus.score, 12'h000);
    check("rst_busy", bus.busy, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_dropped", bus.dropped, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_disp_start", bus.disp_start, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single 1-line event, cycle by cycle
    ds0 = ds_count;
    send_hit(2'd0);
    check("lat_pending_e0", bus.pending, 1);
    check("lat_score_e0", bus.score, 12'h000);
    @(negedge clk);
    check("lat_busy_e1", bus.busy, 1);
    check("lat_pending_e1", bus.pending, 0);
    @(negedge clk);
    check("lat_score_e2", bus.score, 12'h001);
    check("lat_ds_e2", bus.disp_start, 0);
    @(negedge clk);
    check("lat_ds_e3", bus.disp_start, 1);
    @(negedge clk);
    check("lat_ds_e4", bus.disp_start, 0);
    wait_idle("lat_idle");
    check("lat_ds_count", ds_count - ds0, 1);
    check("lat_busy_end", bus.busy, 0);

    // Table of accumulating events
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ds0 = ds_count;
      send_hit(vecs[i].lc);
      wait_idle("tbl_idle");
      check("tbl_score", bus.score, vecs[i].exp_score);
      check("tbl_refresh", ds_count - ds0, 1);
    end
    check("tbl_sat", bus.sat, 0);

    // Carry chain 097 + 8 -> 105
    do_reset();
    repeat (12) begin send_hit(2'd3); wait_idle("carry_pre"); end
    send_hit(2'd0); wait_idle("carry_pre");
    check("carry_097", bus.score, 12'h097);
    send_hit(2'd3); wait_idle("carry_idle");
    check("carry_105", bus.score, 12'h105);

    // Saturation at 999
    do_reset();
    repeat (124) begin send_hit(2'd3); wait_idle("sat_pre"); end
    send_hit(2'd1); wait_idle("sat_pre");
    send_hit(2'd0); wait_idle("sat_pre");
    check("sat_996", bus.score, 12'h996);
    check("sat_flag_low", bus.sat, 0);
    send_hit(2'd2); wait_idle("sat_idle");
    check("sat_999", bus.score, 12'h999);
    check("sat_flag", bus.sat, 1);
    ds0 = ds_count;
    send_hit(2'd0); wait_idle("sat_idle2");
    check("sat_hold", bus.score, 12'h999);
    check("sat_sticky", bus.sat, 1);
    check("sat_refresh", ds_count - ds0, 1);
    ds0 = ds_count;
    bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
    wait_idle("sat_clear");
    check("sat_clear_score", bus.score, 12'h000);
    check("sat_clear_flag", bus.sat, 0);
    check("sat_clear_refresh", ds_count - ds0, 1);

    // Asynchronous reset in the middle of an add
    do_reset();
    send_hit(2'd3);
    @(negedge clk); @(negedge clk);
    check("arst_pre_score", bus.score, 12'h001);
    #2 rst = 1'b0;
    #1;
    check("arst_score", bus.score, 12'h000);
    check("arst_busy", bus.busy, 0);
    @(negedge clk); rst = 1'b1; @(negedge clk);

    // FIFO overflow while an 8-point add is running
    do_reset();
    ds0 = ds_count;
    send_hit(2'd3);
    for (int i = 0; i < 5; i++) begin
      bus.hit = 1'b1; bus.lineCount = 2'd0;
      @(negedge clk);
      if (i == 3) begin
        check("ovf_pending4", bus.pending, 4);
        check("ovf_no_drop_yet", bus.dropped, 0);
      end
      if (i == 4) check("ovf_dropped", bus.dropped, 1);
    end
    bus.hit = 1'b0;
    @(negedge clk);
    check("ovf_drop_pulse", bus.dropped, 0);
    wait_idle("ovf_idle");
    check("ovf_score", bus.score, 12'h012);
    check("ovf_refresh", ds_count - ds0, 5);

    // Clear during ADD with two entries pending and a coincident hit
    do_reset();
    ds0 = ds_count;
    send_hit(2'd3);
    bus.hit = 1'b1; bus.lineCount = 2'd0;
    @(negedge clk); @(negedge clk);
    check("clr_pending2", bus.pending, 2);
    bus.clear = 1'b1; bus.hit = 1'b1; bus.lineCount = 2'd3;
    @(negedge clk);
    bus.clear = 1'b0; bus.hit = 1'b0;
    check("clr_flush", bus.pending, 0);
    check("clr_no_drop", bus.dropped, 0);
    wait_idle("clr_idle");
    check("clr_score", bus.score, 12'h000);
    check("clr_refresh", ds_count - ds0, 1);

    // Busy handshake: held off in REQ, then a 20-cycle transfer
    do_reset();
    ds0 = ds_count;
    force_busy = 1'b1; shifter_len = 20;
    send_hit(2'd0);
    n = 0;
    repeat (12) begin @(negedge clk); if (bus.disp_start) n++; end
    check("hs_no_start", n, 0);
    check("hs_busy_req", bus.busy, 1);
    force_busy = 1'b0;
    @(negedge clk);
    check("hs_start", bus.disp_start, 1);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    // disp_busy high for 20 cycles; WAIT leaves on the edge after it falls
    check("hs_wait_len", n, 21);
    check("hs_refresh", ds_count - ds0, 1);
    shifter_len = 0;

    // Randomized events and clears against a decimal model
    do_reset();
    exp_score = 0; exp_sat = 1'b0; exp_ds = 0; ds0 = ds_count;
    for (int it = 0; it < 60; it++) begin
      shifter_len = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) begin
        bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
        exp_score = 0; exp_sat = 1'b0; exp_ds++;
      end else begin
        k = $urandom_range(1, DEPTH);
        for (int j = 0; j < k; j++) begin
          lc  = 2'($urandom_range(0, 3));
          pts = pts_tab[lc];
          bus.hit = 1'b1; bus.lineCount = lc;
          @(negedge clk);
          if (exp_score + pts > 999) begin
            exp_sat   = 1'b1;
            exp_score = 999;
          end else begin
            exp_score = exp_score + pts;
          end
        end
        bus.hit = 1'b0;
        exp_ds += k;
      end
      wait_idle("rnd_idle");
      check("rnd_score", bus.score, to_bcd(exp_score));
      check("rnd_sat", bus.sat, exp_sat);
      check("rnd_refresh", ds_count - ds0, exp_ds);
    end

    check("digits_0_to_9", digit_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
